// File: rtl/mem_bridge.sv
// mem_bridge: bridges a single-beat core load/store port onto an external
// word-addressed bus with byte enables, lane steering and a REQ timeout.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   mem_r, mem_w        core read / write request (write wins when both set)
//   fetch               instruction-fetch attribute of the request
//   mem_sz              0=byte, 1=half, 2/3=word
//   mem_addr, mem_wdata core byte address, right-aligned write data
//   mem_rdata           right-aligned, zero-extended read result (registered)
//   mem_busy            stall to the core
//   bus_req .. bus_wdata  external bus request, held stable during REQ
//   bus_ack, bus_rdata  bus completion strobe and read word
//   bus_timeout         sticky flag, set when a request times out
//
// state | meaning
// IDLE  | waiting for mem_r|mem_w; request captured on acceptance
// REQ   | bus_req asserted, waiting for bus_ack or timeout
// DONE  | result valid on mem_rdata for one cycle, no new request taken
module mem_bridge #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic        fetch,
  input  logic [1:0]  mem_sz,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_busy,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_fetch,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state_q;
  logic          bus_req_q, bus_we_q, bus_fetch_q, timeout_q;
  logic [31:0]   bus_addr_q, bus_wdata_q, rdata_q;
  logic [3:0]    bus_be_q;
  logic [1:0]    sz_q, off_q;
  logic [CW-1:0] cnt_q;

  logic [3:0]    be_d;
  logic [31:0]   wdata_d, rdata_d, rd_sh;

  // Lane steering from the live core inputs; captured only on acceptance.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = mem_wdata;
    case (mem_sz)
      2'd0: begin
        be_d    = 4'b0001 << mem_addr[1:0];
        wdata_d = {4{mem_wdata[7:0]}};
      end
      2'd1: begin
        be_d    = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{mem_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = mem_wdata;
      end
    endcase
  end

  // Read extraction uses the captured size/offset, not the live core inputs.
  always_comb begin
    rd_sh   = bus_rdata;
    rdata_d = bus_rdata;
    case (sz_q)
      2'd0: begin
        rd_sh   = bus_rdata >> {off_q, 3'b000};
        rdata_d = {24'h0, rd_sh[7:0]};
      end
      2'd1: begin
        rd_sh   = bus_rdata >> {off_q[1], 4'b0000};
        rdata_d = {16'h0, rd_sh[15:0]};
      end
      default: begin
        rd_sh   = bus_rdata;
        rdata_d = bus_rdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_fetch_q <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      sz_q        <= 2'd0;
      off_q       <= 2'd0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_r | mem_w) begin
            state_q     <= REQ;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_w;
            bus_fetch_q <= fetch;
            bus_addr_q  <= {mem_addr[31:2], 2'b00};
            bus_be_q    <= be_d;
            bus_wdata_q <= wdata_d;
            sz_q        <= mem_sz;
            off_q       <= mem_addr[1:0];
            cnt_q       <= '0;
          end
        end
        REQ: begin
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (bus_ack) begin
            state_q   <= DONE;
            bus_req_q <= 1'b0;
            rdata_q   <= bus_we_q ? 32'h0 : rdata_d;
          end else if (cnt_q == CNT_TC) begin
            state_q   <= DONE;
            bus_req_q <= 1'b0;
            rdata_q   <= 32'hFFFF_FFFF;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: state_q <= IDLE;
        default: begin
          state_q   <= IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_busy    = ((state_q == IDLE) & (mem_r | mem_w)) | (state_q == REQ);
  assign mem_rdata   = rdata_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_fetch   = bus_fetch_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_timeout = timeout_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge with TIMEOUT=4; expected values hand-computed.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r, mem_w, fetch;
  logic [1:0]  mem_sz;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_busy;
  logic        bus_req, bus_we, bus_fetch;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_timeout;

  int total = 0;
  int bad   = 0;
  int nb;

  always #5 clk = ~clk;

  mem_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_r(mem_r), .mem_w(mem_w), .fetch(fetch), .mem_sz(mem_sz),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_busy(mem_busy), .bus_req(bus_req), .bus_we(bus_we),
    .bus_fetch(bus_fetch), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_timeout(bus_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; mem_r = 0; mem_w = 0; fetch = 0; mem_sz = 0;
    mem_addr = 0; mem_wdata = 0; bus_ack = 0; bus_rdata = 0;
    #3;
    chk("rst_req",   32'(bus_req), 0);
    chk("rst_busy",  32'(mem_busy), 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_addr",  bus_addr, 0);
    chk("rst_be",    32'(bus_be), 0);
    chk("rst_tmo",   32'(bus_timeout), 0);
    step(); step();
    rst = 1'b1;
    step();

    // Byte read at 0x1003, ack in 3rd REQ cycle: busy for 4 cycles.
    nb = 0;
    mem_r = 1; mem_sz = 2'd0; mem_addr = 32'h1003; #1;
    nb += int'(mem_busy);
    step(); mem_r = 0; #1;
    nb += int'(mem_busy);
    chk("a_req",  32'(bus_req), 1);
    chk("a_addr", bus_addr, 32'h1000);
    chk("a_be",   32'(bus_be), 32'h8);
    chk("a_we",   32'(bus_we), 0);
    step(); nb += int'(mem_busy);
    step(); bus_ack = 1; bus_rdata = 32'hAABBCCDD; #1;
    nb += int'(mem_busy);
    step(); bus_ack = 0; bus_rdata = 0;
    mem_r = 1; mem_sz = 2'd1; mem_addr = 32'h4002; fetch = 1; #1;
    nb += int'(mem_busy);
    chk("a_rdata", mem_rdata, 32'h000000AA);
    chk("a_busy_done_req", 32'(mem_busy), 0);
    chk("a_busycnt", 32'(nb), 4);

    // Half read at 0x4002 as a fetch, accepted once back in IDLE.
    step(); #1;
    chk("h_busy_idle", 32'(mem_busy), 1);
    chk("h_rdata_held", mem_rdata, 32'h000000AA);
    step(); mem_r = 0; fetch = 0; #1;
    chk("h_fetch", 32'(bus_fetch), 1);
    chk("h_be",    32'(bus_be), 32'h0000000C);
    bus_ack = 1; bus_rdata = 32'hAABBCCDD;
    step(); bus_ack = 0; #1;
    chk("h_rdata", mem_rdata, 32'h0000AABB);
    step();

    // Ack outside REQ is ignored.
    bus_ack = 1; bus_rdata = 32'h12121212;
    step(); step(); bus_ack = 0; #1;
    chk("ack_idle_rdata", mem_rdata, 32'h0000AABB);
    chk("ack_idle_req",   32'(bus_req), 0);

    // Half write at 0x2002; core changes address/data during REQ.
    nb = 0;
    mem_w = 1; mem_sz = 2'd1; mem_addr = 32'h2002; mem_wdata = 32'h12345678; #1;
    nb += int'(mem_busy);
    step(); mem_w = 0; mem_addr = 32'h5555_5555; mem_wdata = 32'h0; mem_sz = 2'd2; #1;
    nb += int'(mem_busy);
    chk("w_addr",  bus_addr, 32'h2000);
    chk("w_be",    32'(bus_be), 32'hC);
    chk("w_wdata", bus_wdata, 32'h56785678);
    chk("w_we",    32'(bus_we), 1);
    bus_ack = 1; bus_rdata = 32'hFFFF0000;
    step(); bus_ack = 0; #1;
    nb += int'(mem_busy);
    chk("w_rdata", mem_rdata, 32'h0);
    chk("w_busycnt", 32'(nb), 2);
    step();

    // Byte read offset 1.
    mem_r = 1; mem_sz = 2'd0; mem_addr = 32'h0000_7001;
    step(); mem_r = 0; #1;
    chk("b1_be", 32'(bus_be), 32'h2);
    bus_ack = 1; bus_rdata = 32'hAABBCCDD;
    step(); bus_ack = 0; #1;
    chk("b1_rdata", mem_rdata, 32'h000000CC);
    step();

    // Read and write both set: write wins, word passes through.
    mem_r = 1; mem_w = 1; mem_sz = 2'd2; mem_addr = 32'h3001; mem_wdata = 32'hCAFEBABE;
    step(); mem_r = 0; mem_w = 0; #1;
    chk("rw_we",    32'(bus_we), 1);
    chk("rw_be",    32'(bus_be), 32'hF);
    chk("rw_addr",  bus_addr, 32'h3000);
    chk("rw_wdata", bus_wdata, 32'hCAFEBABE);
    bus_ack = 1;
    step(); bus_ack = 0;
    step();

    // Ack in the same cycle as timeout: ack wins, no flag.
    mem_r = 1; mem_sz = 2'd3; mem_addr = 32'h0000_8000;
    step(); mem_r = 0;
    step(); step(); step();
    #1;
    chk("race_req", 32'(bus_req), 1);
    bus_ack = 1; bus_rdata = 32'h89ABCDEF;
    step(); bus_ack = 0; #1;
    chk("race_rdata", mem_rdata, 32'h89ABCDEF);
    chk("race_tmo",   32'(bus_timeout), 0);
    step();

    // Timeout after 4 REQ cycles without ack.
    mem_r = 1; mem_sz = 2'd2; mem_addr = 32'h5000;
    step(); mem_r = 0;
    step(); step(); step(); #1;
    chk("t_req4", 32'(bus_req), 1);
    step(); #1;
    chk("t_req_done", 32'(bus_req), 0);
    chk("t_rdata", mem_rdata, 32'hFFFFFFFF);
    chk("t_flag",  32'(bus_timeout), 1);
    step();

    // Good access afterwards: flag remains set.
    mem_r = 1; mem_sz = 2'd2; mem_addr = 32'h6000;
    step(); mem_r = 0; bus_ack = 1; bus_rdata = 32'h01020304;
    step(); bus_ack = 0; #1;
    chk("g_rdata", mem_rdata, 32'h01020304);
    chk("g_flag",  32'(bus_timeout), 1);
    step();

    // Reset asserted in the 2nd REQ cycle.
    mem_r = 1; mem_sz = 2'd2; mem_addr = 32'h9000;
    step(); mem_r = 0;
    step(); #1;
    chk("r_req_before", 32'(bus_req), 1);
    rst = 1'b0; #1;
    chk("r_req",   32'(bus_req), 0);
    chk("r_busy",  32'(mem_busy), 0);
    chk("r_rdata", mem_rdata, 32'h0);
    chk("r_flag",  32'(bus_timeout), 0);
    bus_ack = 1; bus_rdata = 32'h77777777;
    step(); rst = 1'b1;
    step(); step(); bus_ack = 0; #1;
    chk("r_rdata_after", mem_rdata, 32'h0);
    chk("r_req_after",   32'(bus_req), 0);
    chk("r_busy_after",  32'(mem_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, meaning the number of REQ-state cycles without bus_ack before forced termination.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; it is asynchronous and active-low.
REQ-004 SHALL have port mem_r, input, 1, core read request.
REQ-005 SHALL have port mem_w, input, 1, core write request.
REQ-006 SHALL have port fetch, input, 1, marks the request as an instruction fetch.
REQ-007 SHALL have port mem_sz, input, 2, access size: 0=byte, 1=half, 2=word, 3=word.
REQ-008 SHALL have port mem_addr, input, 32, core byte address.
REQ-009 SHALL have port mem_wdata, input, 32, core write data, right-aligned.
REQ-010 SHALL have port mem_rdata, output, 32, read data to core, right-aligned and zero-extended.
REQ-011 SHALL have port mem_busy, output, 1, stall to core.
REQ-012 SHALL have port bus_req, output, 1, external bus request.
REQ-013 SHALL have port bus_we, output, 1, external bus write enable.
REQ-014 SHALL have port bus_fetch, output, 1, instruction-fetch attribute.
REQ-015 SHALL have port bus_addr, output, 32, word address with bits [1:0] always 0.
REQ-016 SHALL have port bus_be, output, 4, byte enables.
REQ-017 SHALL have port bus_wdata, output, 32, lane-steered write data.
REQ-018 SHALL have port bus_ack, input, 1, bus completion strobe.
REQ-019 SHALL have port bus_rdata, input, 32, bus read word, valid when bus_ack=1.
REQ-020 SHALL have port bus_timeout, output, 1, sticky timeout flag.

Function
REQ-021 SHALL implement FSM states IDLE, REQ, DONE.
REQ-022 SHALL accept a request in IDLE when mem_r|mem_w=1, latching we=mem_w, fetch, mem_sz, mem_addr and mem_wdata, then SHALL go to REQ.
REQ-023 SHALL give priority to write when mem_r and mem_w are both 1.
REQ-024 SHALL drive mem_busy = (IDLE & (mem_r|mem_w)) | REQ, combinationally; mem_busy SHALL be 0 in DONE.
REQ-025 SHALL drive bus_req=1 only in REQ, and SHALL hold bus_addr, bus_be, bus_wdata, bus_we and bus_fetch stable from the latched values throughout REQ, regardless of core inputs.
REQ-026 SHALL set bus_addr = {addr[31:2], 2'b00}.
REQ-027 SHALL generate bus_be as follows: byte gives 1<<addr[1:0]; half gives 4'b0011 when addr[1]=0, else 4'b1100; word (sz 2 or 3) gives 4'b1111.
REQ-028 SHALL generate bus_wdata as follows: byte replicates wdata[7:0] into all 4 lanes; half replicates wdata[15:0] into both halves; word passes wdata unchanged.
REQ-029 SHALL ignore addr[0] for half accesses and addr[1:0] for word accesses; misaligned accesses SHALL NOT be split.
REQ-030 SHALL, on bus_ack in REQ, register the read result and go to DONE; write acks SHALL register 0.
REQ-031 SHALL form the read result by shifting bus_rdata right by 8*addr[1:0] for byte or 16*addr[1] for half, then zero-extending to 8 or 16 bits; word SHALL pass bus_rdata unchanged.
REQ-032 SHALL drive mem_rdata from the registered result at all times; the value SHALL be valid in DONE and held until the next completion.
REQ-033 SHALL transition DONE to IDLE unconditionally after 1 cycle; a new request SHALL NOT be accepted in DONE.
REQ-034 SHALL make minimum latency from acceptance to DONE = 2 cycles with bus_ack in the first REQ cycle; the core-visible stall SHALL be 2 cycles.
REQ-035 SHALL count REQ cycles with a counter cleared on entry to REQ; when the count reaches TIMEOUT without ack, it SHALL go to DONE with result 32'hFFFFFFFF and set bus_timeout=1.
REQ-036 SHALL let bus_ack win if bus_ack and timeout occur in the same cycle, with no flag set.
REQ-037 SHALL ignore bus_ack outside REQ.
REQ-038 SHALL clear bus_timeout only by reset.

Reset
REQ-039 SHALL, while rst=0, force state=IDLE, bus_req=0, bus_we=0, bus_fetch=0, bus_addr=0, bus_be=0, bus_wdata=0, mem_rdata=0, counter=0 and bus_timeout=0, asynchronously.
REQ-040 SHALL, on reset assertion mid-REQ, drop bus_req immediately and discard the transaction with no completion.
REQ-041 SHALL keep mem_busy at 0 while rst=0 if mem_r=mem_w=0.

Verification
REQ-042 SHALL be verified with this scenario: byte read, addr=0x1003, bus_rdata=0xAABBCCDD, ack after 3 cycles -> bus_addr=0x1000, be=1000, mem_rdata=0x000000AA in DONE, busy for 4 cycles.
REQ-043 SHALL be verified with this scenario: half write, addr=0x2002, wdata=0x12345678 -> be=1100, bus_wdata=0x56785678, bus_we=1.
REQ-044 SHALL be verified with this scenario: word read with mem_r and mem_w both 1 -> bus_we=1 (write wins).
REQ-045 SHALL be verified with this scenario: TIMEOUT=4 and no ack -> DONE after 4 REQ cycles, mem_rdata=0xFFFFFFFF, bus_timeout=1, and the flag stays set after the next good access.
REQ-046 SHALL be verified with this scenario: core changes mem_addr during REQ -> bus_addr is unchanged.
REQ-047 SHALL be verified with this scenario: rst low in the 2nd REQ cycle -> bus_req=0 the same cycle, state IDLE, and no mem_rdata update.
